mux_p21: RTL and testbench
==========================

# mux_p21

Two-input, one-select multiplexer used as a generic datapath steering primitive. Combinational output `out` returns lane 1 of `in` when `sel` is 1 and lane 0 when `sel` is 0. A registered copy `out_q` gives consumers a flopped version of the same selection on the block's single clock. Sits wherever a 2:1 choice between two packed lanes is needed, e.g. operand or bypass selection.

## Interface
Parameters:
- `WIDTH`, default 1: bits per data lane.
- `REG_OUT`, default 0: 1 drives `out` from the register instead of combinationally; 0 keeps `out` combinational.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `in`  input  2*WIDTH  packed lanes: lane 0 = `in[WIDTH-1:0]`, lane 1 = `in[2*WIDTH-1:WIDTH]`.
- `sel`  input  1  lane select: 0 selects lane 0, 1 selects lane 1.
- `out`  output  WIDTH  selected lane; combinational when `REG_OUT`=0, equal to `out_q` when `REG_OUT`=1.
- `out_q`  output  WIDTH  registered selected lane.

## Operation
- Selection function: `mux = sel ? lane1 : lane0`.
- `out` (`REG_OUT`=0): purely combinational; no dependence on `clk` or `rst`.
- `out_q`: updated on every rising `clk` edge to the current `mux` value.
- `rst`=1 at a rising edge: `out_q` takes all-zeros. `rst` has priority over the data update.
- `rst` has no effect on the combinational `out` when `REG_OUT`=0.
- `sel` is one bit. Any wider driver is truncated to its LSB by the connecting net, so a value of -1 or 3 selects lane 1.
- No X-propagation handling. An X on `sel` yields X on `out`, per standard simulation semantics.
- Lanes are independent of each other. No arithmetic, no width extension.

## Timing
- Combinational path: `out` settles within the same delta as any change to `in` or `sel`. Latency 0.
- Registered path: `out_q` reflects the `in`/`sel` values present at rising edge N, visible after edge N. Latency 1 cycle.
- Reset value: `out_q` = 0. `out` = 0 when `REG_OUT`=1, otherwise it follows the inputs.
- `rst` deasserted at edge N: `out_q` loads the selection at edge N+1 (first non-reset edge).
- `rst` asserted mid-stream: the next edge clears `out_q`, and the pending selection is discarded.
- No handshake. The block accepts new inputs on every cycle.

## Structure
- Single module `mux_p21`, no sub-modules.
- No shared package is required. The lane-index constants `LANE0=0` and `LANE1=1` may live in the common datapath package if one exists.
- The combinational selector and the output flop form one always_comb block plus one always_ff block.

## Test plan
- `REG_OUT`=0, `WIDTH`=1: sweep all 8 combinations of `in`∈{00,01,10,11} and `sel`∈{0,1}. Required: `out` = `in[sel]`, e.g. `in`=10, `sel`=1 → `out`=1; `in`=10, `sel`=0 → `out`=0.
- Select truncation: drive `sel` from a signed value of -1 with `in`=01. Required: `out`=0, because lane 1 is selected.
- Reset: hold `rst`=1 for 2 cycles with `in`=11, `sel`=1. Required: `out_q`=0. After deassertion, `out_q`=1 one edge later.
- Registered latency: `in`=01, `sel`=0 at edge N, then `in`=00 at edge N+1. Required: `out_q`=1 after edge N and 0 after edge N+1.
- `WIDTH`=8, `REG_OUT`=1: `in`={8'hA5, 8'h3C}. Required: `sel`=1 gives `out`=8'hA5 one cycle later; `sel`=0 gives 8'h3C.
- Randomised run: 10 or more cycles of random `in` and `sel`. A scoreboard checks `out` combinationally and `out_q` with a 1-cycle delayed model.

Source files
------------

// File: rtl/mux_p21_pkg.sv
// Lane-index constants and select encoding shared by the 2:1 datapath steering mux.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_p21_pkg;

  // Position of each lane within the packed input bus, counted in lane widths.
  localparam int LANE0 = 0;
  localparam int LANE1 = 1;

  // Select encoding: the raw select bit maps directly onto the lane index.
  typedef enum logic {
    SEL_LANE0 = 1'b0,
    SEL_LANE1 = 1'b1
  } lane_sel_e;

endpackage

// File: rtl/mux_p21.sv
// 2:1 lane selector: out = sel ? lane1 : lane0, plus a flopped copy out_q.
// Latency: 0 cycles on out (REG_OUT=0), 1 cycle on out_q and on out when REG_OUT=1.
// Backpressure: none; a new input is accepted on every clock.
module mux_p21
  import mux_p21_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] in,
  input  logic               sel,
  output logic [WIDTH-1:0]   out,
  output logic [WIDTH-1:0]   out_q
);

  logic [WIDTH-1:0] mux;

  // Lane selection; the ternary keeps standard X behaviour when sel is unknown.
  always_comb begin
    mux = (lane_sel_e'(sel) == SEL_LANE1) ? in[LANE1*WIDTH +: WIDTH]
                                          : in[LANE0*WIDTH +: WIDTH];
  end

  // Output flop: synchronous reset wins over the data load.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= mux;
    end
  end

  // out is either the live selection or the flopped one, fixed at elaboration.
  generate
    if (REG_OUT) begin : g_out_reg
      assign out = out_q;
    end else begin : g_out_comb
      assign out = mux;
    end
  endgenerate

endmodule

// File: tb/tb_mux_p21.sv
// Directed and random checks of mux_p21 at WIDTH=1 and WIDTH=8, both output modes.
// Latency: checks out at 0 cycles and out_q at 1 cycle after the sampling edge.
// Backpressure: none exercised; inputs change every cycle.
module tb_mux_p21;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in1;
  logic       sel1;
  logic       out1;
  logic       outq1;
  logic [15:0] in8;
  logic        sel8;
  logic [7:0]  out8;
  logic [7:0]  outq8;
  logic [7:0]  out8c;
  logic [7:0]  outq8c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_p21 #(.WIDTH(1), .REG_OUT(1'b0)) u_w1 (
    .clk(clk), .rst(rst), .in(in1), .sel(sel1), .out(out1), .out_q(outq1)
  );

  mux_p21 #(.WIDTH(8), .REG_OUT(1'b1)) u_w8r (
    .clk(clk), .rst(rst), .in(in8), .sel(sel8), .out(out8), .out_q(outq8)
  );

  mux_p21 #(.WIDTH(8), .REG_OUT(1'b0)) u_w8c (
    .clk(clk), .rst(rst), .in(in8), .sel(sel8), .out(out8c), .out_q(outq8c)
  );

  typedef struct {
    logic [1:0] in;
    logic       sel;
    logic       exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One rising edge, then step off it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vecs[8];
    int   sel_int;
    logic [7:0] exp_now;
    logic [7:0] exp_prev;

    vecs[0] = '{in: 2'b00, sel: 1'b0, exp: 1'b0};
    vecs[1] = '{in: 2'b00, sel: 1'b1, exp: 1'b0};
    vecs[2] = '{in: 2'b01, sel: 1'b0, exp: 1'b1};
    vecs[3] = '{in: 2'b01, sel: 1'b1, exp: 1'b0};
    vecs[4] = '{in: 2'b10, sel: 1'b0, exp: 1'b0};
    vecs[5] = '{in: 2'b10, sel: 1'b1, exp: 1'b1};
    vecs[6] = '{in: 2'b11, sel: 1'b0, exp: 1'b1};
    vecs[7] = '{in: 2'b11, sel: 1'b1, exp: 1'b1};

    rst  = 1'b1;
    in1  = 2'b11;
    sel1 = 1'b1;
    in8  = {8'hA5, 8'h3C};
    sel8 = 1'b1;

    // Reset held for two edges; combinational out still follows inputs.
    tick();
    tick();
    check("rst_outq_w1", 32'(outq1), 32'd0);
    check("rst_out_w8_reg", 32'(out8), 32'd0);
    check("rst_outq_w8", 32'(outq8), 32'd0);
    check("rst_comb_out_w1", 32'(out1), 32'd1);

    // First non-reset edge loads the selection.
    rst = 1'b0;
    tick();
    check("post_rst_outq_w1", 32'(outq1), 32'd1);
    check("w8_sel1_out", 32'(out8), 32'hA5);

    // Registered mode: changing sel does not show until the next edge.
    sel8 = 1'b0;
    #1;
    check("w8_hold_before_edge", 32'(out8), 32'hA5);
    check("w8_comb_sel0", 32'(out8c), 32'h3C);
    tick();
    check("w8_sel0_out", 32'(out8), 32'h3C);

    // Combinational sweep of all eight WIDTH=1 input patterns.
    for (int i = 0; i < 8; i++) begin
      in1  = vecs[i].in;
      sel1 = vecs[i].sel;
      #1;
      check($sformatf("sweep_%0d", i), 32'(out1), 32'(vecs[i].exp));
    end

    // Select driven from a wider signed value keeps only its LSB.
    sel_int = -1;
    in1  = 2'b01;
    sel1 = 1'(sel_int);
    #1;
    check("sel_trunc_m1", 32'(out1), 32'd0);
    sel_int = 3;
    in1  = 2'b10;
    sel1 = 1'(sel_int);
    #1;
    check("sel_trunc_3", 32'(out1), 32'd1);

    // One-cycle latency on out_q.
    in1  = 2'b01;
    sel1 = 1'b0;
    tick();
    check("lat_edge_n", 32'(outq1), 32'd1);
    in1 = 2'b00;
    tick();
    check("lat_edge_n1", 32'(outq1), 32'd0);

    // Mid-stream reset discards the pending selection.
    in1  = 2'b11;
    sel1 = 1'b1;
    tick();
    check("mid_pre_rst", 32'(outq1), 32'd1);
    in1 = 2'b10;
    rst = 1'b1;
    tick();
    check("mid_rst_clear", 32'(outq1), 32'd0);
    rst = 1'b0;
    tick();
    check("mid_rst_release", 32'(outq1), 32'd1);

    // Random run with a one-cycle delayed reference for the flopped outputs.
    in8  = 16'(($urandom()));
    sel8 = 1'($urandom_range(0, 1));
    exp_prev = sel8 ? in8[15:8] : in8[7:0];
    tick();
    for (int c = 0; c < 16; c++) begin
      check($sformatf("rnd_outq_%0d", c), 32'(outq8c), 32'(exp_prev));
      check($sformatf("rnd_out_reg_%0d", c), 32'(out8), 32'(exp_prev));
      in8  = 16'($urandom());
      sel8 = 1'($urandom_range(0, 1));
      #1;
      exp_now = sel8 ? in8[15:8] : in8[7:0];
      check($sformatf("rnd_comb_%0d", c), 32'(out8c), 32'(exp_now));
      exp_prev = exp_now;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
